// File: rtl/s2p_frame_arbiter_pkg.sv
// s2p_pkg: shared constants, FSM encodings and width helper for the frame arbiter
package s2p_pkg;
  localparam int FRAME_BITS_DEF = 6;
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_LOCK = 1'b1;
  // never returns less than 1 so degenerate parameters still give legal vectors
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/s2p_frame_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick, first requester after i_last wins
module rr_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    i_req,
  input  logic [ID_W-1:0] i_last,
  output logic [ID_W-1:0] o_gnt_id,
  output logic            o_gnt_any
);
  // lowest requester overall is the wrap-around fallback; lowest above i_last overrides it
  always_comb begin
    o_gnt_id  = '0;
    o_gnt_any = 1'b0;
    for (int j = N - 1; j >= 0; j--)
      if (i_req[j]) begin
        o_gnt_id  = ID_W'(j);
        o_gnt_any = 1'b1;
      end
    for (int j = N - 1; j >= 0; j--)
      if (i_req[j] && ID_W'(j) > i_last) o_gnt_id = ID_W'(j);
  end
endmodule

// File: rtl/s2p_frame_arbiter.sv
// s2p_frame_arbiter: round-robin sharing of one serial-to-parallel deserializer among
// NUM_SRC serial sources, with per-frame grant lock, source tagging and stall abort.
module s2p_frame_arbiter
  import s2p_pkg::*;
#(
  parameter int NUM_SRC    = 4,
  parameter int FRAME_BITS = FRAME_BITS_DEF,
  parameter int TIMEOUT    = 16,
  parameter int ID_W       = clog2(NUM_SRC)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] src_valid,
  input  logic [NUM_SRC-1:0] src_data,
  output logic [NUM_SRC-1:0] src_ready,
  output logic               des_valid,
  output logic               des_data,
  input  logic               des_ready,
  output logic               des_flush,
  output logic [ID_W-1:0]    grant_id,
  output logic               busy,
  output logic               frame_done,
  output logic [ID_W-1:0]    frame_src,
  output logic               frame_abort
);
  localparam int CNT_W   = clog2(FRAME_BITS);
  localparam int STALL_W = clog2(TIMEOUT + 1);
  logic [0:0]         r_state;
  logic [ID_W-1:0]    r_grant, r_last, r_fsrc;
  logic [CNT_W-1:0]   r_bit_cnt;
  logic [STALL_W-1:0] r_stall_cnt;
  logic               r_done, r_abort;
  logic               w_lock, w_xfer, w_end, w_stall, w_timeout, w_gnt_any;
  logic [ID_W-1:0]    w_gnt_id, w_last;
  logic [NUM_SRC-1:0] w_req;
  assign w_lock      = r_state == S_LOCK;
  assign busy        = w_lock;
  assign grant_id    = r_grant;
  assign des_valid   = w_lock & src_valid[r_grant];
  assign des_data    = w_lock & src_data[r_grant];
  assign src_ready   = w_lock ? (NUM_SRC'(des_ready) << r_grant) : '0;
  assign w_xfer      = des_valid & des_ready;
  assign w_end       = w_xfer && r_bit_cnt == CNT_W'(FRAME_BITS - 1);
  assign w_stall     = w_lock & ~w_xfer;
  assign w_timeout   = TIMEOUT != 0 && w_stall && r_stall_cnt == STALL_W'(TIMEOUT - 1);
  // at a frame boundary the finishing owner is masked out so another requester takes over
  assign w_req       = w_lock ? src_valid & ~(NUM_SRC'(1) << r_grant) : src_valid;
  assign w_last      = w_lock ? r_grant : r_last;
  assign frame_done  = r_done;
  assign frame_src   = r_fsrc;
  assign frame_abort = r_abort;
  assign des_flush   = r_abort;
  rr_arbiter #(.N(NUM_SRC), .ID_W(ID_W)) u_rr (
    .i_req    (w_req),
    .i_last   (w_last),
    .o_gnt_id (w_gnt_id),
    .o_gnt_any(w_gnt_any)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_grant     <= '0;
      r_last      <= ID_W'(NUM_SRC - 1);
      r_fsrc      <= '0;
      r_bit_cnt   <= '0;
      r_stall_cnt <= '0;
      r_done      <= 1'b0;
      r_abort     <= 1'b0;
    end else begin
      r_done  <= w_end;
      r_abort <= w_timeout;
      if (w_end) r_fsrc <= r_grant;
      if (!w_lock) begin
        r_bit_cnt   <= '0;
        r_stall_cnt <= '0;
        if (w_gnt_any) begin
          r_grant <= w_gnt_id;
          r_state <= S_LOCK;
        end
      end else if (w_timeout) begin
        r_bit_cnt   <= '0;
        r_stall_cnt <= '0;
        r_last      <= r_grant;
        r_state     <= S_IDLE;
      end else if (w_xfer) begin
        r_stall_cnt <= '0;
        r_bit_cnt   <= w_end ? '0 : r_bit_cnt + CNT_W'(1);
        if (w_end) begin
          r_last <= r_grant;
          if (w_gnt_any) r_grant <= w_gnt_id;
          else r_state <= S_IDLE;
        end
      end else if (r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + STALL_W'(1);
    end
endmodule
